// File: rtl/playfield_lock_engine_if.sv
// -----------------------------------------------------------------------------
// playfield_lock_engine_if
// Bundles the game-core / cell-memory signals of playfield_lock_engine.
//   master : game core + memory side (drives piece, request, hit and row flags)
//   slave  : the lock engine (drives outcome pulses, busy, memory writes,
//            row-collapse command and the cleared-line counter)
// Parameters must match the engine instance they are connected to.
// -----------------------------------------------------------------------------
interface playfield_lock_engine_if #(
    parameter int FIELD_H = 21,
    parameter int CELLS   = 4,
    parameter int COLOR_W = 3
);
    logic [5*CELLS-1:0] piece_x;
    logic [5*CELLS-1:0] piece_y;
    logic [COLOR_W-1:0] piece_color;
    logic               move_req;
    logic               move_intent;
    logic [CELLS-1:0]   hit_status;
    logic [FIELD_H-1:0] rowfull;

    logic               move_commit;
    logic               move_declined;
    logic               move_locked;
    logic               busy;
    logic               mem_wr_en;
    logic [4:0]         mem_wr_x;
    logic [4:0]         mem_wr_y;
    logic [COLOR_W-1:0] mem_wr_data;
    logic [FIELD_H-1:0] rowshift;
    logic [15:0]        lines_total;

    modport master (
        output piece_x, piece_y, piece_color, move_req, move_intent,
               hit_status, rowfull,
        input  move_commit, move_declined, move_locked, busy, mem_wr_en,
               mem_wr_x, mem_wr_y, mem_wr_data, rowshift, lines_total
    );

    modport slave (
        input  piece_x, piece_y, piece_color, move_req, move_intent,
               hit_status, rowfull,
        output move_commit, move_declined, move_locked, busy, mem_wr_en,
               mem_wr_x, mem_wr_y, mem_wr_data, rowshift, lines_total
    );
endinterface

// File: rtl/playfield_lock_engine.sv
// -----------------------------------------------------------------------------
// playfield_lock_engine
// Playfield movement / lock controller between the game core and cell memory.
// After reset it paints the well border (left wall, floor, right wall), then
// arbitrates move requests using the memory's per-cell hit flags. A blocked
// gravity step commits the piece into memory one cell per cycle, one row up
// from the proposed position.
//
// Optional feature macro: LINE_CLEAR_EN
//   defined   : after a lock, full rows (floor excluded) are collapsed lowest
//               first via one-hot rowshift pulses and counted in lines_total.
//   undefined : lock goes straight to DONE, rowshift and lines_total are 0,
//               rowfull is ignored.
//
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : playfield_lock_engine_if.slave (piece/request inputs, hit and
//           row flags, outcome pulses, busy, memory write port, rowshift,
//           lines_total). All outputs are registered.
// -----------------------------------------------------------------------------
module playfield_lock_engine #(
    parameter int FIELD_W    = 12,
    parameter int FIELD_H    = 21,
    parameter int CELLS      = 4,
    parameter int COLOR_W    = 3,
    parameter int SETTLE     = 12,
    parameter int WALL_COLOR = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    playfield_lock_engine_if.slave  bus
);

    localparam int IDX_W = 6;
    localparam logic [COLOR_W-1:0] WALL = COLOR_W'(WALL_COLOR);

    typedef enum logic [3:0] {
        ST_INIT_L, ST_INIT_F, ST_INIT_R, ST_IDLE, ST_WAIT,
        ST_DECIDE, ST_LOCK, ST_SCAN, ST_SHIFT, ST_DONE
    } state_t;

`ifdef LINE_CLEAR_EN
    localparam state_t AFTER_LOCK = ST_SCAN;
`else
    localparam state_t AFTER_LOCK = ST_DONE;
`endif

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;       // init position / lock cell index
    logic [7:0]           cnt_q, cnt_d;       // settle counter
    logic                 intent_q, intent_d;
    logic [5*CELLS-1:0]   px_q, px_d;
    logic [5*CELLS-1:0]   py_q, py_d;
    logic [COLOR_W-1:0]   color_q, color_d;

    logic                 commit_q, commit_d;
    logic                 declined_q, declined_d;
    logic                 locked_q, locked_d;
    logic                 busy_q, busy_d;
    logic                 wr_en_q, wr_en_d;
    logic [4:0]           wr_x_q, wr_x_d;
    logic [4:0]           wr_y_q, wr_y_d;
    logic [COLOR_W-1:0]   wr_data_q, wr_data_d;

    logic                 lock_wr;
    logic [4:0]           cell_x [CELLS];
    logic [4:0]           cell_y [CELLS];
    logic [4:0]           sel_x, sel_y;

    // Unpack the latched piece into per-cell coordinates.
    for (genvar gi = 0; gi < CELLS; gi++) begin : g_cell
        assign cell_x[gi] = px_q[5*gi +: 5];
        assign cell_y[gi] = py_q[5*gi +: 5];
    end

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int k = 0; k < CELLS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_x = cell_x[k];
                sel_y = cell_y[k];
            end
        end
    end

`ifdef LINE_CLEAR_EN
    localparam logic [FIELD_H-1:0] ROW_ONE = FIELD_H'(1);

    logic [4:0]           row_q, row_d;
    logic [FIELD_H-1:0]   rowshift_q, rowshift_d;
    logic [15:0]          lines_q, lines_d;
    logic                 full_any;
    logic [4:0]           full_row;

    // Lowest-numbered full row wins; the floor row never counts as full.
    always_comb begin
        full_any = 1'b0;
        full_row = '0;
        for (int r = FIELD_H - 2; r >= 0; r--) begin
            if (bus.rowfull[r]) begin
                full_any = 1'b1;
                full_row = 5'(r);
            end
        end
    end
`else
    logic unused_rowfull;
    assign unused_rowfull = ^bus.rowfull;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        intent_d   = intent_q;
        px_d       = px_q;
        py_d       = py_q;
        color_d    = color_q;
        commit_d   = 1'b0;
        declined_d = 1'b0;
        locked_d   = 1'b0;
        // busy trails the state by one cycle so it drops the cycle after an
        // outcome pulse and after the last border write.
        busy_d     = (state_q != ST_IDLE);
        wr_en_d    = 1'b0;
        wr_x_d     = wr_x_q;
        wr_y_d     = wr_y_q;
        wr_data_d  = wr_data_q;
        lock_wr    = 1'b0;
`ifdef LINE_CLEAR_EN
        row_d      = row_q;
        rowshift_d = '0;
        lines_d    = lines_q;
`endif

        case (state_q)
            ST_INIT_L: begin
                wr_en_d   = 1'b1;
                wr_x_d    = 5'd0;
                wr_y_d    = idx_q[4:0];
                wr_data_d = WALL;
                if (idx_q == IDX_W'(FIELD_H - 1)) begin
                    idx_d   = '0;
                    state_d = ST_INIT_F;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_INIT_F: begin
                wr_en_d   = 1'b1;
                wr_x_d    = idx_q[4:0];
                wr_y_d    = 5'(FIELD_H - 1);
                wr_data_d = WALL;
                if (idx_q == IDX_W'(FIELD_W - 1)) begin
                    idx_d   = '0;
                    state_d = ST_INIT_R;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_INIT_R: begin
                wr_en_d   = 1'b1;
                wr_x_d    = 5'(FIELD_W - 1);
                wr_y_d    = idx_q[4:0];
                wr_data_d = WALL;
                if (idx_q == IDX_W'(FIELD_H - 1)) begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_IDLE: begin
                if (bus.move_req) begin
                    intent_d = bus.move_intent;
                    px_d     = bus.piece_x;
                    py_d     = bus.piece_y;
                    color_d  = bus.piece_color;
                    idx_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 8'(SETTLE - 1)) begin
                    state_d = ST_DECIDE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DECIDE: begin
                if (bus.hit_status == '0) begin
                    commit_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (intent_q) begin
                    declined_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    // Cell 0 is written on the decision edge so the lock
                    // writes follow the decision without a gap cycle.
                    lock_wr = 1'b1;
                end
            end
            ST_LOCK: begin
                lock_wr = 1'b1;
            end
`ifdef LINE_CLEAR_EN
            ST_SCAN: begin
                if (full_any) begin
                    row_d   = full_row;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == 8'd0) begin
                    rowshift_d = ROW_ONE << row_q;
                    if (lines_q != 16'hFFFF) begin
                        lines_d = lines_q + 16'd1;
                    end
                end
                // One command cycle plus SETTLE cycles for the memory to
                // collapse the row and refresh its full flags.
                if (cnt_q == 8'(SETTLE)) begin
                    state_d = ST_SCAN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`endif
            ST_DONE: begin
                locked_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Commit one cell one row above its blocked position; y = 0 wraps
        // to 31, which the memory ignores.
        if (lock_wr) begin
            wr_en_d   = 1'b1;
            wr_x_d    = sel_x;
            wr_y_d    = sel_y - 5'd1;
            wr_data_d = color_q;
            if (idx_q == IDX_W'(CELLS - 1)) begin
                idx_d   = '0;
                state_d = AFTER_LOCK;
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = ST_LOCK;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_INIT_L;
            idx_q      <= '0;
            cnt_q      <= '0;
            intent_q   <= 1'b0;
            px_q       <= '0;
            py_q       <= '0;
            color_q    <= '0;
            commit_q   <= 1'b0;
            declined_q <= 1'b0;
            locked_q   <= 1'b0;
            busy_q     <= 1'b1;
            wr_en_q    <= 1'b0;
            wr_x_q     <= '0;
            wr_y_q     <= '0;
            wr_data_q  <= WALL;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            intent_q   <= intent_d;
            px_q       <= px_d;
            py_q       <= py_d;
            color_q    <= color_d;
            commit_q   <= commit_d;
            declined_q <= declined_d;
            locked_q   <= locked_d;
            busy_q     <= busy_d;
            wr_en_q    <= wr_en_d;
            wr_x_q     <= wr_x_d;
            wr_y_q     <= wr_y_d;
            wr_data_q  <= wr_data_d;
        end
    end

`ifdef LINE_CLEAR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q      <= '0;
            rowshift_q <= '0;
            lines_q    <= '0;
        end else begin
            row_q      <= row_d;
            rowshift_q <= rowshift_d;
            lines_q    <= lines_d;
        end
    end

    assign bus.rowshift    = rowshift_q;
    assign bus.lines_total = lines_q;
`else
    assign bus.rowshift    = '0;
    assign bus.lines_total = '0;
`endif

    assign bus.move_commit   = commit_q;
    assign bus.move_declined = declined_q;
    assign bus.move_locked   = locked_q;
    assign bus.busy          = busy_q;
    assign bus.mem_wr_en     = wr_en_q;
    assign bus.mem_wr_x      = wr_x_q;
    assign bus.mem_wr_y      = wr_y_q;
    assign bus.mem_wr_data   = wr_data_q;

endmodule

// File: tb/tb_playfield_lock_engine.sv
// -----------------------------------------------------------------------------
// tb_playfield_lock_engine
// Directed bench for playfield_lock_engine at default parameters. Expected
// values are hand-computed; line-clear expectations depend on LINE_CLEAR_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_playfield_lock_engine;

    localparam int FIELD_W = 12;
    localparam int FIELD_H = 21;
    localparam int CELLS   = 4;
    localparam int COLOR_W = 3;
    localparam int SETTLE  = 12;
`ifdef LINE_CLEAR_EN
    localparam int LC = 1;
`else
    localparam int LC = 0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    playfield_lock_engine_if #(.FIELD_H(FIELD_H), .CELLS(CELLS), .COLOR_W(COLOR_W)) bus ();

    playfield_lock_engine #(
        .FIELD_W(FIELD_W), .FIELD_H(FIELD_H), .CELLS(CELLS),
        .COLOR_W(COLOR_W), .SETTLE(SETTLE), .WALL_COLOR(6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { int cyc; int x; int y; int d; } wr_t;
    typedef struct { int cyc; int val; } rs_t;
    wr_t wr_q[$];
    rs_t rs_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] pack4(input int a, input int b, input int c, input int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    // Runs from reset release until busy falls; cycle 0 is the first edge.
    task automatic run_init(input int drop_req_at, output int n_wr, output int order_bad,
                            output int data_bad, output int busy_low_at, output int n_pulses);
        int ex, ey;
        n_wr = 0; order_bad = 0; data_bad = 0; busy_low_at = -1; n_pulses = 0;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (n == drop_req_at) bus.move_req = 1'b0;
            if (bus.move_commit || bus.move_declined || bus.move_locked) n_pulses++;
            if (bus.mem_wr_en) begin
                if (n_wr < FIELD_H) begin
                    ex = 0; ey = n_wr;
                end else if (n_wr < FIELD_H + FIELD_W) begin
                    ex = n_wr - FIELD_H; ey = FIELD_H - 1;
                end else begin
                    ex = FIELD_W - 1; ey = n_wr - FIELD_H - FIELD_W;
                end
                if (int'(bus.mem_wr_x) != ex || int'(bus.mem_wr_y) != ey) order_bad++;
                if (bus.mem_wr_data != 3'd6) data_bad++;
                n_wr++;
            end
            if (!bus.busy) begin
                busy_low_at = n;
                break;
            end
        end
        $display("init: writes=%0d order_bad=%0d data_bad=%0d busy_low@%0d", n_wr, order_bad, data_bad, busy_low_at);
    endtask

    // Issues one request; cycle numbers are relative to the sampling edge T.
    task automatic run_move(input logic intent, input logic [3:0] hit,
                            input logic [19:0] px, input logic [19:0] py,
                            input logic [2:0] col, input logic [20:0] rf,
                            output int commit_at, output int declined_at,
                            output int locked_at, output int n_pulses,
                            output int busy_low_at);
        commit_at = -1; declined_at = -1; locked_at = -1; n_pulses = 0; busy_low_at = -1;
        wr_q.delete();
        rs_q.delete();
        bus.move_req    = 1'b1;
        bus.move_intent = intent;
        bus.piece_x     = px;
        bus.piece_y     = py;
        bus.piece_color = col;
        bus.hit_status  = hit;
        bus.rowfull     = rf;
        tick();
        // Scramble the piece inputs so only the latched copy can be used.
        bus.move_req    = 1'b0;
        bus.move_intent = ~intent;
        bus.piece_x     = '0;
        bus.piece_y     = '0;
        bus.piece_color = '0;
        for (int n = 1; n <= 120; n++) begin
            tick();
            if (bus.move_commit) begin n_pulses++; if (commit_at < 0) commit_at = n; end
            if (bus.move_declined) begin n_pulses++; if (declined_at < 0) declined_at = n; end
            if (bus.move_locked) begin n_pulses++; if (locked_at < 0) locked_at = n; end
            if (bus.mem_wr_en)
                wr_q.push_back('{n, int'(bus.mem_wr_x), int'(bus.mem_wr_y), int'(bus.mem_wr_data)});
            if (bus.rowshift != '0) begin
                rs_q.push_back('{n, int'(bus.rowshift)});
                bus.rowfull = bus.rowfull & ~bus.rowshift;
            end
            if (!bus.busy && (commit_at >= 0 || declined_at >= 0 || locked_at >= 0)) begin
                busy_low_at = n;
                break;
            end
        end
        $display("move: intent=%0d hit=%b commit@%0d declined@%0d locked@%0d writes=%0d shifts=%0d lines=%0d",
                 intent, hit, commit_at, declined_at, locked_at, wr_q.size(), rs_q.size(), bus.lines_total);
    endtask

    task automatic check_lock_writes(input string tag, input int xs[4], input int ys[4], input int d);
        logic [31:0] obs, exp;
        check_val({tag, "_count"}, 32'(wr_q.size()), 32'(CELLS));
        for (int i = 0; i < CELLS; i++) begin
            exp = {8'(SETTLE + 1 + i), 8'(xs[i]), 8'(ys[i]), 8'(d)};
            if (i < wr_q.size()) obs = {8'(wr_q[i].cyc), 8'(wr_q[i].x), 8'(wr_q[i].y), 8'(wr_q[i].d)};
            else obs = 32'hFFFF_FFFF;
            check_val($sformatf("%s_wr%0d", tag, i), obs, exp);
        end
    endtask

    int c_at, d_at, l_at, np, bl_at;
    int nw, ob, db;
    int xs[4], ys[4];

    initial begin
        bus.move_req    = 1'b0;
        bus.move_intent = 1'b0;
        bus.piece_x     = '0;
        bus.piece_y     = '0;
        bus.piece_color = '0;
        bus.hit_status  = '0;
        bus.rowfull     = '0;

        // Reset values
        #12;
        check_val("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
        check_val("rst_busy", 32'(bus.busy), 32'd1);
        check_val("rst_data", 32'(bus.mem_wr_data), 32'd6);
        check_val("rst_addr", {22'd0, bus.mem_wr_x, bus.mem_wr_y}, 32'd0);
        check_val("rst_pulses", {29'd0, bus.move_commit, bus.move_declined, bus.move_locked}, 32'd0);
        check_val("rst_rowshift", 32'(bus.rowshift), 32'd0);
        check_val("rst_lines", 32'(bus.lines_total), 32'd0);

        // Border painting
        tick();
        reset = 1'b1;
        run_init(-1, nw, ob, db, bl_at, np);
        check_val("init_writes", 32'(nw), 32'(2 * FIELD_H + FIELD_W));
        check_val("init_order", 32'(ob), 32'd0);
        check_val("init_data", 32'(db), 32'd0);
        check_val("init_busy_low", 32'(bl_at), 32'(2 * FIELD_H + FIELD_W));
        check_val("init_pulses", 32'(np), 32'd0);
        tick();

        // User move, no hit: commit
        run_move(1'b1, 4'b0000, pack4(5, 6, 5, 6), pack4(3, 3, 4, 4), 3'd2, '0, c_at, d_at, l_at, np, bl_at);
        check_val("commit_at", 32'(c_at), 32'(SETTLE + 1));
        check_val("commit_pulses", 32'(np), 32'd1);
        check_val("commit_writes", 32'(wr_q.size()), 32'd0);
        check_val("commit_busy_low", 32'(bl_at), 32'(SETTLE + 2));

        // User move, hit: declined
        run_move(1'b1, 4'b0010, pack4(5, 6, 5, 6), pack4(3, 3, 4, 4), 3'd2, '0, c_at, d_at, l_at, np, bl_at);
        check_val("declined_at", 32'(d_at), 32'(SETTLE + 1));
        check_val("declined_pulses", 32'(np), 32'd1);
        check_val("declined_writes", 32'(wr_q.size()), 32'd0);
        check_val("declined_lines", 32'(bus.lines_total), 32'd0);

        // Gravity blocked: lock
        run_move(1'b0, 4'b0100, pack4(5, 6, 5, 6), pack4(3, 3, 4, 4), 3'd2, '0, c_at, d_at, l_at, np, bl_at);
        xs = '{5, 6, 5, 6}; ys = '{2, 2, 3, 3};
        check_lock_writes("lock", xs, ys, 2);
        check_val("lock_locked_at", 32'(l_at), 32'(SETTLE + CELLS + 1 + LC));
        check_val("lock_pulses", 32'(np), 32'd1);
        check_val("lock_shifts", 32'(rs_q.size()), 32'd0);

        // Lock with a cell on row 0: address wraps to 31
        run_move(1'b0, 4'b1000, pack4(3, 4, 5, 6), pack4(0, 1, 2, 3), 3'd5, '0, c_at, d_at, l_at, np, bl_at);
        xs = '{3, 4, 5, 6}; ys = '{31, 0, 1, 2};
        check_lock_writes("wrap", xs, ys, 5);
        check_val("wrap_locked_at", 32'(l_at), 32'(SETTLE + CELLS + 1 + LC));

        // Lock with rows 7 and 9 full; floor flag must be ignored
        run_move(1'b0, 4'b0100, pack4(5, 6, 5, 6), pack4(3, 3, 4, 4), 3'd2,
                 21'((1 << 7) | (1 << 9) | (1 << 20)), c_at, d_at, l_at, np, bl_at);
        xs = '{5, 6, 5, 6}; ys = '{2, 2, 3, 3};
        check_lock_writes("clear", xs, ys, 2);
        check_val("clear_shifts", 32'(rs_q.size()), 32'(2 * LC));
        check_val("clear_locked_at", 32'(l_at), 32'(SETTLE + CELLS + 1 + LC * (1 + 2 * (SETTLE + 2))));
        check_val("clear_lines", 32'(bus.lines_total), 32'(2 * LC));
`ifdef LINE_CLEAR_EN
        if (rs_q.size() == 2) begin
            check_val("clear_shift0", {8'(rs_q[0].cyc), 24'(rs_q[0].val)}, {8'd18, 24'(1 << 7)});
            check_val("clear_shift1", {8'(rs_q[1].cyc), 24'(rs_q[1].val)}, {8'd32, 24'(1 << 9)});
        end
`endif
        tick();

        // Reset during LOCK
        bus.move_req    = 1'b1;
        bus.move_intent = 1'b0;
        bus.piece_x     = pack4(5, 6, 5, 6);
        bus.piece_y     = pack4(3, 3, 4, 4);
        bus.piece_color = 3'd2;
        bus.hit_status  = 4'b0001;
        bus.rowfull     = '0;
        tick();
        bus.move_req = 1'b0;
        for (int n = 1; n <= SETTLE + 2; n++) tick();
        check_val("abort_pre_wr_en", 32'(bus.mem_wr_en), 32'd1);
        reset = 1'b0;
        #1;
        check_val("abort_wr_en", 32'(bus.mem_wr_en), 32'd0);
        check_val("abort_busy", 32'(bus.busy), 32'd1);
        check_val("abort_data", 32'(bus.mem_wr_data), 32'd6);
        check_val("abort_addr", {22'd0, bus.mem_wr_x, bus.mem_wr_y}, 32'd0);
        check_val("abort_lines", 32'(bus.lines_total), 32'd0);
        tick();
        tick();
        bus.move_req    = 1'b1;
        bus.move_intent = 1'b1;
        bus.hit_status  = 4'b0000;
        reset = 1'b1;
        run_init(40, nw, ob, db, bl_at, np);
        check_val("reinit_writes", 32'(nw), 32'(2 * FIELD_H + FIELD_W));
        check_val("reinit_order", 32'(ob), 32'd0);
        check_val("reinit_busy_low", 32'(bl_at), 32'(2 * FIELD_H + FIELD_W));
        check_val("reinit_req_ignored", 32'(np), 32'd0);
        tick();
        check_val("reinit_idle_quiet", {30'd0, bus.busy, bus.move_commit}, 32'd0);

        // Normal operation after re-init
        run_move(1'b1, 4'b0000, pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), 3'd1, '0, c_at, d_at, l_at, np, bl_at);
        check_val("post_commit_at", 32'(c_at), 32'(SETTLE + 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
